// File: rtl/spi_burst_control_if.sv
// Handshake and register-bus bundle for spi_burst_control.
// master: the burst controller side; slave: the client / IP side.
interface spi_burst_control_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned LEN_W = 4
);
    logic             I_START;
    logic [LEN_W-1:0] I_LEN;
    logic [2:0]       I_SS_SEL;
    logic [DW-1:0]    I_TX_DATA;
    logic             I_TX_VLD;
    logic             O_TX_RDY;
    logic [DW-1:0]    O_RX_DATA;
    logic             O_RX_VLD;
    logic             O_BUSY;
    logic             O_DONE;
    logic             O_ERR;
    logic             O_TX_EN;
    logic [2:0]       O_WADDR;
    logic [DW-1:0]    O_WDATA;
    logic             O_RX_EN;
    logic [2:0]       O_RADDR;
    logic [DW-1:0]    I_RDATA;

    modport master (
        input  I_START, I_LEN, I_SS_SEL, I_TX_DATA, I_TX_VLD, I_RDATA,
        output O_TX_RDY, O_RX_DATA, O_RX_VLD, O_BUSY, O_DONE, O_ERR,
        output O_TX_EN, O_WADDR, O_WDATA, O_RX_EN, O_RADDR
    );

    modport slave (
        output I_START, I_LEN, I_SS_SEL, I_TX_DATA, I_TX_VLD, I_RDATA,
        input  O_TX_RDY, O_RX_DATA, O_RX_VLD, O_BUSY, O_DONE, O_ERR,
        input  O_TX_EN, O_WADDR, O_WDATA, O_RX_EN, O_RADDR
    );
endinterface

// File: rtl/spi_burst_control.sv
// Drives a register-mapped SPI IP through a burst of word transfers.
// Optional status-poll timeout is enabled by defining SPI_BURST_TIMEOUT_EN.
module spi_burst_control #(
    parameter int unsigned DW      = 8,
    parameter int unsigned LEN_W   = 4,
    parameter logic [7:0]  CTRL_ON = 8'h8B,
    parameter int unsigned TO_CYC  = 1024
) (
    input  logic I_CLK,
    input  logic I_RESET,
    spi_burst_control_if.master bus
);
    localparam logic [2:0] A_RXDATA  = 3'd0;
    localparam logic [2:0] A_TXDATA  = 3'd1;
    localparam logic [2:0] A_STATUS  = 3'd2;
    localparam logic [2:0] A_CONTROL = 3'd3;
    localparam logic [2:0] A_SSMASK  = 3'd4;

    typedef enum logic [3:0] {
        IDLE, SSMASK, CTRL, POLL_TRDY, GET_TX, WR_TX, POLL_RRDY, RD_RX, CTRL_OFF, FIN
    } state_t;

    state_t           st, st_nx;
    logic [1:0]       ph, ph_nx;
    logic [LEN_W-1:0] len_q, cnt;
    logic [2:0]       sel_q;
    logic [DW-1:0]    tx_q, rdata_q;
    logic [7:0]       ss_onehot;
    logic             start_d, armed, err;
    logic             start_rise, polling, timeout;

    // armed blocks a start that was already high when reset released
    assign start_rise = bus.I_START & ~start_d & armed;
    assign polling    = (st == POLL_TRDY) || (st == POLL_RRDY);
    assign ss_onehot  = 8'd1 << sel_q;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] poll_cnt;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET)       poll_cnt <= '0;
        else if (!polling) poll_cnt <= '0;
        else               poll_cnt <= poll_cnt + TW'(1);
    end

    assign timeout = polling && (poll_cnt == TW'(TO_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            st <= IDLE;
            ph <= '0;
        end else begin
            st <= st_nx;
            ph <= ph_nx;
        end
    end

    // ph sequences the sub-cycles of a register access: 0-1 for writes, 0-3 for reads
    always_comb begin
        st_nx         = st;
        ph_nx         = ph + 2'd1;
        bus.O_TX_EN   = 1'b0;
        bus.O_WADDR   = '0;
        bus.O_WDATA   = '0;
        bus.O_RX_EN   = 1'b0;
        bus.O_RADDR   = '0;
        bus.O_TX_RDY  = 1'b0;
        bus.O_RX_VLD  = 1'b0;
        bus.O_RX_DATA = '0;
        bus.O_DONE    = 1'b0;
        unique case (st)
            IDLE: begin
                ph_nx = '0;
                if (start_rise) st_nx = SSMASK;
            end
            SSMASK: begin
                bus.O_TX_EN = (ph == 2'd0);
                bus.O_WADDR = A_SSMASK;
                bus.O_WDATA = DW'(ss_onehot);
                if (ph == 2'd1) begin st_nx = CTRL; ph_nx = '0; end
            end
            CTRL: begin
                bus.O_TX_EN = (ph == 2'd0);
                bus.O_WADDR = A_CONTROL;
                bus.O_WDATA = DW'(CTRL_ON);
                if (ph == 2'd1) begin st_nx = POLL_TRDY; ph_nx = '0; end
            end
            POLL_TRDY: begin
                bus.O_RX_EN = (ph == 2'd0);
                bus.O_RADDR = A_STATUS;
                if (ph == 2'd3 && rdata_q[5] && rdata_q[4]) begin
                    st_nx = GET_TX; ph_nx = '0;
                end else if (timeout) begin
                    st_nx = CTRL_OFF; ph_nx = '0;
                end
            end
            GET_TX: begin
                bus.O_TX_RDY = 1'b1;
                ph_nx        = '0;
                if (bus.I_TX_VLD) st_nx = WR_TX;
            end
            WR_TX: begin
                bus.O_TX_EN = (ph == 2'd0);
                bus.O_WADDR = A_TXDATA;
                bus.O_WDATA = tx_q;
                if (ph == 2'd1) begin st_nx = POLL_RRDY; ph_nx = '0; end
            end
            POLL_RRDY: begin
                bus.O_RX_EN = (ph == 2'd0);
                bus.O_RADDR = A_STATUS;
                if (ph == 2'd3 && rdata_q[6]) begin
                    st_nx = RD_RX; ph_nx = '0;
                end else if (timeout) begin
                    st_nx = CTRL_OFF; ph_nx = '0;
                end
            end
            RD_RX: begin
                bus.O_RX_EN = (ph == 2'd0);
                bus.O_RADDR = A_RXDATA;
                if (ph == 2'd2) begin
                    bus.O_RX_VLD  = 1'b1;
                    bus.O_RX_DATA = bus.I_RDATA;
                end
                if (ph == 2'd3) st_nx = (cnt == len_q) ? CTRL_OFF : POLL_TRDY;
            end
            CTRL_OFF: begin
                bus.O_TX_EN = (ph == 2'd0);
                bus.O_WADDR = A_CONTROL;
                if (ph == 2'd1) begin st_nx = FIN; ph_nx = '0; end
            end
            FIN: begin
                bus.O_DONE = 1'b1;
                st_nx      = IDLE;
                ph_nx      = '0;
            end
            default: begin
                st_nx = IDLE;
                ph_nx = '0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            start_d <= 1'b0;
            armed   <= 1'b0;
            len_q   <= '0;
            sel_q   <= '0;
            cnt     <= '0;
            tx_q    <= '0;
            rdata_q <= '0;
            err     <= 1'b0;
        end else begin
            start_d <= bus.I_START;
            if (!bus.I_START) armed <= 1'b1;
            if (st == IDLE && start_rise) begin
                len_q <= bus.I_LEN;
                sel_q <= bus.I_SS_SEL;
                cnt   <= '0;
                err   <= 1'b0;
            end
            if (st == GET_TX && bus.I_TX_VLD) tx_q <= bus.I_TX_DATA;
            if (polling && ph == 2'd2) rdata_q <= bus.I_RDATA;
            // stops at len_q, so a full-range burst never wraps the counter
            if (st == RD_RX && ph == 2'd3 && cnt != len_q) cnt <= cnt + LEN_W'(1);
            if (polling && st_nx == CTRL_OFF) err <= 1'b1;
        end
    end

    assign bus.O_BUSY = (st != IDLE);
    assign bus.O_ERR  = err;
endmodule
